// File: rtl/rx_huge_page_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the RX huge-page controller.
// Optional stall counter is enabled by defining RX_HP_STALL_CNT_EN.
package rx_huge_page_ctrl_pkg;

  localparam int HP_PAGE_BYTES  = 2097152;
  localparam int HP_PAGE_QWORDS = HP_PAGE_BYTES / 8;
  localparam int HP_OFFSET_W    = $clog2(HP_PAGE_QWORDS) + 1;
  localparam int HP_HDR_QWORDS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_HDR,
    ST_SWAP,
    ST_ACK
  } hp_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_hp_slot_regs.sv
// Huge-page slot bases and ready flags, with writes to the busy slot deferred
// until the controller is idle again.
module rx_hp_slot_regs
  import rx_huge_page_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              cur_slot,
  input  logic              busy,
  input  logic              idle,
  input  logic              clr_en,
  output logic [1:0]        hp_ready,
  output logic [ADDR_W-1:0] base_cur
);

  logic [ADDR_W-1:0] base_q [2];
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] wr_masked;
  logic              pend_vld;
  logic              pend_sel;
  logic              defer;
  logic              wr_now;
  logic              pend_apply;

  assign wr_masked = wr_addr & ~ADDR_W'(7);
  assign defer     = wr_en && (wr_sel == cur_slot) && busy;
  assign wr_now    = wr_en && !defer;
  // A fresh direct write to the same slot supersedes the parked one.
  assign pend_apply = pend_vld && idle && !(wr_now && (wr_sel == pend_sel));

  // Parked write is forwarded so an IDLE-cycle accept already sees the new base.
  assign base_cur = (idle && pend_vld && (pend_sel == cur_slot)) ? pend_addr : base_q[cur_slot];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld <= 1'b0;
      pend_sel <= 1'b0;
      hp_ready <= 2'b00;
    end else begin
      if (defer) begin
        pend_vld <= 1'b1;
        pend_sel <= wr_sel;
      end else if (pend_vld && idle) begin
        pend_vld <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (clr_en && (cur_slot == 1'(i))) hp_ready[i] <= 1'b0;
        if ((wr_now && (wr_sel == 1'(i))) || (pend_apply && (pend_sel == 1'(i))))
          hp_ready[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (defer) pend_addr <= wr_masked;
    for (int i = 0; i < 2; i++) begin
      if (wr_now && (wr_sel == 1'(i)))            base_q[i] <= wr_masked;
      else if (pend_apply && (pend_sel == 1'(i))) base_q[i] <= pend_addr;
    end
  end

endmodule

// File: rtl/rx_huge_page_ctrl.sv
// RX huge-page placement controller: turns trigger requests into addressed TLPs
// and runs the header-write / page-swap close sequence. Optional: RX_HP_STALL_CNT_EN.
module rx_huge_page_ctrl
  import rx_huge_page_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int OFFSET_W   = HP_OFFSET_W,
  parameter int HDR_QWORDS = HP_HDR_QWORDS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hp_wr_en,
  input  logic                hp_wr_sel,
  input  logic [ADDR_W-1:0]   hp_wr_addr,
  output logic [1:0]          hp_ready,
  input  logic                trigger_tlp,
  output logic                trigger_tlp_ack,
  input  logic                change_huge_page,
  input  logic                send_last_tlp,
  output logic                change_huge_page_ack,
  input  logic [4:0]          qwords_to_send,
  output logic                tlp_req,
  input  logic                tlp_gnt,
  output logic [ADDR_W-1:0]   tlp_host_addr,
  output logic [4:0]          tlp_qwords,
  output logic                tlp_is_hdr,
  output logic [OFFSET_W-1:0] tlp_hdr_data,
`ifdef RX_HP_STALL_CNT_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic                cur_slot
);

  hp_state_e             state;
  logic                  last_q;
  logic [OFFSET_W-1:0]   offset;
  logic [OFFSET_W-1:0]   next_off;
  logic [ADDR_W-1:0]     off_bytes;
  logic [ADDR_W-1:0]     base_cur;
  logic                  req_any;
  logic                  can_take;

  rx_hp_slot_regs #(.ADDR_W(ADDR_W)) u_slot_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (hp_wr_en),
    .wr_sel   (hp_wr_sel),
    .wr_addr  (hp_wr_addr),
    .cur_slot (cur_slot),
    .busy     ((state == ST_DATA) || (state == ST_HDR)),
    .idle     (state == ST_IDLE),
    .clr_en   (state == ST_SWAP),
    .hp_ready (hp_ready),
    .base_cur (base_cur)
  );

  assign off_bytes = {{(ADDR_W-OFFSET_W-3){1'b0}}, offset, 3'b000};
  assign next_off  = offset + OFFSET_W'(tlp_qwords);
  assign req_any   = change_huge_page || send_last_tlp || trigger_tlp;
  // The requester still holds its line during the ack cycle, so no accept then.
  assign can_take  = hp_ready[cur_slot] && !trigger_tlp_ack && !change_huge_page_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_IDLE;
      last_q               <= 1'b0;
      offset               <= OFFSET_W'(HDR_QWORDS);
      cur_slot             <= 1'b0;
      trigger_tlp_ack      <= 1'b0;
      change_huge_page_ack <= 1'b0;
      tlp_req              <= 1'b0;
      tlp_host_addr        <= '0;
      tlp_qwords           <= '0;
      tlp_is_hdr           <= 1'b0;
      tlp_hdr_data         <= '0;
    end else begin
      trigger_tlp_ack      <= 1'b0;
      change_huge_page_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any && can_take) begin
            tlp_req <= 1'b1;
            if (change_huge_page) begin
              state         <= ST_HDR;
              tlp_is_hdr    <= 1'b1;
              tlp_qwords    <= 5'd1;
              tlp_host_addr <= base_cur;
              tlp_hdr_data  <= offset;
            end else begin
              state         <= ST_DATA;
              last_q        <= send_last_tlp;
              tlp_is_hdr    <= 1'b0;
              tlp_qwords    <= qwords_to_send;
              tlp_host_addr <= base_cur + off_bytes;
            end
          end
        end
        ST_DATA: begin
          if (tlp_gnt) begin
            offset <= next_off;
            if (last_q) begin
              state         <= ST_HDR;
              tlp_is_hdr    <= 1'b1;
              tlp_qwords    <= 5'd1;
              tlp_host_addr <= base_cur;
              tlp_hdr_data  <= next_off;
            end else begin
              state           <= ST_IDLE;
              tlp_req         <= 1'b0;
              trigger_tlp_ack <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (tlp_gnt) begin
            state      <= ST_SWAP;
            tlp_req    <= 1'b0;
            tlp_is_hdr <= 1'b0;
          end
        end
        ST_SWAP: begin
          cur_slot             <= ~cur_slot;
          offset               <= OFFSET_W'(HDR_QWORDS);
          change_huge_page_ack <= 1'b1;
          state                <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RX_HP_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
    end else if ((state == ST_IDLE) && req_any && !hp_ready[cur_slot]) begin
      stall_cycles <= sat_inc32(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_rx_huge_page_ctrl.sv
// Self-checking bench for rx_huge_page_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level page model.
module tb_rx_huge_page_ctrl;

  localparam int K_TRIG = 0;
  localparam int K_LAST = 1;
  localparam int K_CHG  = 2;

  localparam logic [63:0] B0 = 64'h1_0000_0000;
  localparam logic [63:0] B1 = 64'h2_0040_0000;
  localparam logic [63:0] B2 = 64'h3_0000_0007;
  localparam logic [63:0] B3 = 64'h0_8000_0000;
  localparam logic [63:0] B4 = 64'h5_5555_5000;
  localparam logic [63:0] B5 = 64'h6_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hp_wr_en;
  logic        hp_wr_sel;
  logic [63:0] hp_wr_addr;
  logic [1:0]  hp_ready;
  logic        trigger_tlp;
  logic        trigger_tlp_ack;
  logic        change_huge_page;
  logic        send_last_tlp;
  logic        change_huge_page_ack;
  logic [4:0]  qwords_to_send;
  logic        tlp_req;
  logic        tlp_gnt;
  logic [63:0] tlp_host_addr;
  logic [4:0]  tlp_qwords;
  logic        tlp_is_hdr;
  logic [18:0] tlp_hdr_data;
  logic        cur_slot;
`ifdef RX_HP_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  rx_huge_page_ctrl dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .hp_wr_en             (hp_wr_en),
    .hp_wr_sel            (hp_wr_sel),
    .hp_wr_addr           (hp_wr_addr),
    .hp_ready             (hp_ready),
    .trigger_tlp          (trigger_tlp),
    .trigger_tlp_ack      (trigger_tlp_ack),
    .change_huge_page     (change_huge_page),
    .send_last_tlp        (send_last_tlp),
    .change_huge_page_ack (change_huge_page_ack),
    .qwords_to_send       (qwords_to_send),
    .tlp_req              (tlp_req),
    .tlp_gnt              (tlp_gnt),
    .tlp_host_addr        (tlp_host_addr),
    .tlp_qwords           (tlp_qwords),
    .tlp_is_hdr           (tlp_is_hdr),
    .tlp_hdr_data         (tlp_hdr_data),
`ifdef RX_HP_STALL_CNT_EN
    .stall_cycles         (stall_cycles),
`endif
    .cur_slot             (cur_slot)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_tack = 0;
  int n_cack = 0;

  always @(negedge clk) begin
    if (trigger_tlp_ack) n_tack = n_tack + 1;
    if (change_huge_page_ack) n_cack = n_cack + 1;
  end

  // Page model: per-slot base and ownership, active slot, running qword offset.
  logic [63:0] m_base [2];
  logic [1:0]  m_ready = 2'b00;
  logic        m_slot = 1'b0;
  int          m_off = 16;

  logic        def_wr = 1'b0;
  logic        def_sel = 1'b0;
  logic [63:0] def_addr = '0;

  typedef struct {
    int          kind;
    logic [4:0]  qw;
    int          dly;
    logic [63:0] addr;
    logic [18:0] hdr;
    logic [1:0]  rdy;
    logic        slot;
  } vec_t;

  vec_t tbl [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hp_write(input logic sel, input logic [63:0] addr);
    hp_wr_en = 1'b1;
    hp_wr_sel = sel;
    hp_wr_addr = addr;
    tick;
    hp_wr_en = 1'b0;
    m_base[sel] = addr & ~64'h7;
    m_ready[sel] = 1'b1;
  endtask

  task automatic get_tlp(input int dly, output logic [63:0] a, output logic [4:0] q,
                         output logic h, output logic [18:0] d, output bit ok);
    int w;
    bit stable;
    w = 0;
    stable = 1'b1;
    while (!tlp_req && w < 300) begin
      tick;
      w++;
    end
    if (!tlp_req) begin
      chk("req_timeout", 64'(tlp_req), 64'd1);
      a = '0; q = '0; h = 1'b0; d = '0; ok = 1'b0;
      return;
    end
    a = tlp_host_addr; q = tlp_qwords; h = tlp_is_hdr; d = tlp_hdr_data; ok = 1'b1;
    for (int i = 0; i < dly; i++) begin
      if (i == 0 && def_wr) begin
        hp_wr_en = 1'b1;
        hp_wr_sel = def_sel;
        hp_wr_addr = def_addr;
      end
      tick;
      hp_wr_en = 1'b0;
      if (!tlp_req || tlp_host_addr !== a || tlp_qwords !== q || tlp_is_hdr !== h ||
          (h && tlp_hdr_data !== d)) stable = 1'b0;
    end
    def_wr = 1'b0;
    chk("fields_stable", 64'(stable), 64'd1);
    tlp_gnt = 1'b1;
    tick;
    tlp_gnt = 1'b0;
  endtask

  task automatic xact(input int kind, input logic [4:0] qw, input int dly,
                      output logic [63:0] data_addr, output logic [18:0] hdr_val);
    logic [63:0] a;
    logic [4:0]  q;
    logic        h;
    logic [18:0] d;
    bit          ok;
    int          t0, c0, lat;
    t0 = n_tack;
    c0 = n_cack;
    data_addr = '0;
    hdr_val = '0;
    qwords_to_send = qw;
    if (kind == K_TRIG) trigger_tlp = 1'b1;
    else if (kind == K_LAST) send_last_tlp = 1'b1;
    else change_huge_page = 1'b1;
    if (kind != K_CHG) begin
      get_tlp(dly, a, q, h, d, ok);
      if (ok) begin
        chk("data_addr", a, m_base[m_slot] + 64'(m_off) * 64'd8);
        chk("data_qwords", 64'(q), 64'(qw));
        chk("data_is_hdr", 64'(h), 64'd0);
      end
      data_addr = a;
      m_off = m_off + int'(qw);
    end
    if (kind != K_TRIG) begin
      get_tlp(dly, a, q, h, d, ok);
      if (ok) begin
        chk("hdr_addr", a, m_base[m_slot]);
        chk("hdr_qwords", 64'(q), 64'd1);
        chk("hdr_is_hdr", 64'(h), 64'd1);
        chk("hdr_data", 64'(d), 64'(m_off));
      end
      hdr_val = d;
      m_ready[m_slot] = 1'b0;
      m_slot = ~m_slot;
      m_off = 16;
    end
    lat = 0;
    while (!((kind == K_TRIG) ? trigger_tlp_ack : change_huge_page_ack) && lat < 8) begin
      tick;
      lat++;
    end
    if (kind == K_TRIG) trigger_tlp = 1'b0;
    else if (kind == K_LAST) send_last_tlp = 1'b0;
    else change_huge_page = 1'b0;
    chk("ack_latency", 64'(lat), (kind == K_TRIG) ? 64'd0 : 64'd1);
    repeat (3) tick;
    chk("trig_ack_count", 64'(n_tack - t0), (kind == K_TRIG) ? 64'd1 : 64'd0);
    chk("chg_ack_count", 64'(n_cack - c0), (kind == K_TRIG) ? 64'd0 : 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] da;
    logic [18:0] hv;
    logic [63:0] a;
    logic [4:0]  q;
    logic        h;
    logic [18:0] d;
    bit          ok;
    int          cnt, t0, w, r;

    tbl[0] = '{K_TRIG, 5'd16, 0, B0 + 64'h80,  19'd0,  2'b11, 1'b0};
    tbl[1] = '{K_TRIG, 5'd16, 3, B0 + 64'h100, 19'd0,  2'b11, 1'b0};
    tbl[2] = '{K_TRIG, 5'd16, 7, B0 + 64'h180, 19'd0,  2'b11, 1'b0};
    tbl[3] = '{K_LAST, 5'd5,  2, B0 + 64'h200, 19'd69, 2'b10, 1'b1};
    tbl[4] = '{K_TRIG, 5'd16, 1, B1 + 64'h80,  19'd0,  2'b10, 1'b1};
    tbl[5] = '{K_LAST, 5'd5,  0, B1 + 64'h100, 19'd37, 2'b00, 1'b0};

    reset_n = 1'b0;
    hp_wr_en = 1'b0; hp_wr_sel = 1'b0; hp_wr_addr = '0;
    trigger_tlp = 1'b0; change_huge_page = 1'b0; send_last_tlp = 1'b0;
    qwords_to_send = '0; tlp_gnt = 1'b0;
    tick; tick;
    chk("rst_tlp_req", 64'(tlp_req), 64'd0);
    chk("rst_trig_ack", 64'(trigger_tlp_ack), 64'd0);
    chk("rst_chg_ack", 64'(change_huge_page_ack), 64'd0);
    chk("rst_hp_ready", 64'(hp_ready), 64'd0);
    chk("rst_cur_slot", 64'(cur_slot), 64'd0);
    chk("rst_addr", tlp_host_addr, 64'd0);
    chk("rst_qwords", 64'(tlp_qwords), 64'd0);
    chk("rst_is_hdr", 64'(tlp_is_hdr), 64'd0);
    chk("rst_hdr_data", 64'(tlp_hdr_data), 64'd0);
    reset_n = 1'b1;
    tick;

    // Slot 0 unowned: trigger must stall without any request or ack.
    hp_write(1'b1, B1);
    trigger_tlp = 1'b1;
    qwords_to_send = 5'd16;
    cnt = 0;
    repeat (100) begin
      tick;
      if (tlp_req || trigger_tlp_ack || change_huge_page_ack) cnt++;
    end
    chk("stall_activity", 64'(cnt), 64'd0);
    hp_write(1'b0, B0);

    for (int i = 0; i < 6; i++) begin
      xact(tbl[i].kind, tbl[i].qw, tbl[i].dly, da, hv);
      chk($sformatf("tbl%0d_addr", i), da, tbl[i].addr);
      if (tbl[i].kind != K_TRIG) chk($sformatf("tbl%0d_hdr", i), 64'(hv), 64'(tbl[i].hdr));
      chk($sformatf("tbl%0d_ready", i), 64'(hp_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_slot", i), 64'(cur_slot), 64'(tbl[i].slot));
    end

    // Close and trigger together: empty-page header first, then data in slot 1.
    hp_write(1'b0, B2);
    hp_write(1'b1, B3);
    trigger_tlp = 1'b1;
    qwords_to_send = 5'd8;
    xact(K_CHG, 5'd8, 1, da, hv);
    chk("empty_hdr", 64'(hv), 64'd16);
    chk("swap_ready", 64'(hp_ready), 64'(2'b10));
    chk("swap_slot", 64'(cur_slot), 64'd1);
    xact(K_TRIG, 5'd8, 0, da, hv);
    chk("post_swap_addr", da, B3 + 64'h80);

    // Base rewrite of the active slot while its data request is pending.
    def_wr = 1'b1;
    def_sel = 1'b1;
    def_addr = B4;
    xact(K_TRIG, 5'd4, 3, da, hv);
    chk("deferred_old_addr", da, B3 + 64'hC0);
    m_base[1] = B4;
    xact(K_TRIG, 5'd4, 0, da, hv);
    chk("deferred_new_addr", da, B4 + 64'hE0);

    // Write to the slot being released lands in SWAP and keeps it owned.
    change_huge_page = 1'b1;
    get_tlp(1, a, q, h, d, ok);
    chk("swapwr_hdr_data", 64'(d), 64'd32);
    chk("swapwr_hdr_addr", a, B4);
    hp_wr_en = 1'b1;
    hp_wr_sel = 1'b1;
    hp_wr_addr = B5;
    tick;
    hp_wr_en = 1'b0;
    chk("swapwr_ack", 64'(change_huge_page_ack), 64'd1);
    chk("swapwr_ready", 64'(hp_ready), 64'(2'b10));
    chk("swapwr_slot", 64'(cur_slot), 64'd0);
    change_huge_page = 1'b0;
    repeat (3) tick;
    m_base[1] = B5;
    m_ready = 2'b10;
    m_slot = 1'b0;
    m_off = 16;

    for (int n = 0; n < 40; n++) begin
      if (!m_ready[m_slot]) hp_write(m_slot, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) hp_write(~m_slot, {$urandom, $urandom});
      r = int'($urandom_range(0, 9));
      xact((r < 7) ? K_TRIG : ((r < 9) ? K_LAST : K_CHG), 5'($urandom_range(1, 16)),
           int'($urandom_range(0, 4)), da, hv);
      chk("rand_ready", 64'(hp_ready), 64'(m_ready));
      chk("rand_slot", 64'(cur_slot), 64'(m_slot));
    end

    // Reset with a request outstanding.
    if (!m_ready[m_slot]) hp_write(m_slot, B0);
    trigger_tlp = 1'b1;
    qwords_to_send = 5'd3;
    w = 0;
    while (!tlp_req && w < 50) begin
      tick;
      w++;
    end
    chk("midrst_pre_req", 64'(tlp_req), 64'd1);
    t0 = n_tack;
    reset_n = 1'b0;
    #1;
    chk("midrst_req", 64'(tlp_req), 64'd0);
    chk("midrst_addr", tlp_host_addr, 64'd0);
    chk("midrst_qwords", 64'(tlp_qwords), 64'd0);
    chk("midrst_ready", 64'(hp_ready), 64'd0);
    chk("midrst_slot", 64'(cur_slot), 64'd0);
    trigger_tlp = 1'b0;
    tick;
    reset_n = 1'b1;
    repeat (20) tick;
    chk("midrst_no_ack", 64'(n_tack - t0), 64'd0);
    chk("midrst_idle_req", 64'(tlp_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_huge_page_ctrl.md
Name: rx_huge_page_ctrl

Overview:
- Sequences host-memory placement for the RX path: owns the two driver-supplied 2 MB huge-page slots, converts trigger requests into addressed TLP-issue requests, and performs the page-close/swap protocol.
- Sits between rx_tlp_trigger (upstream: trigger_tlp / change_huge_page handshakes) and the TLP sender (downstream: req/gnt).
- Each page reserves its first HDR_QWORDS qwords for a header; on close, the ctrl writes the final qword count there before handing the page back.

Parameters:
- ADDR_W, 64, host address width.
- OFFSET_W, 19, qword offset width within a huge page (2 MB = 2^18 qwords, plus overflow bit).
- HDR_QWORDS, 16, qwords reserved at page start; also the offset reset value.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- hp_wr_en  in  1  driver writes a page base address (1-cycle pulse)
- hp_wr_sel  in  1  slot index for the write
- hp_wr_addr  in  ADDR_W  page base address; bits [2:0] are ignored (treated as 0)
- hp_ready  out  2  per-slot "owned by HW" flags
- trigger_tlp  in  1  data TLP request from the trigger block
- trigger_tlp_ack  out  1  1-cycle ack
- change_huge_page  in  1  close-page request
- send_last_tlp  in  1  data TLP followed by close
- change_huge_page_ack  out  1  1-cycle ack for close / last
- qwords_to_send  in  5  qword count, 1..16
- tlp_req  out  1  request to the sender
- tlp_gnt  in  1  sender accepted the current request (1 cycle)
- tlp_host_addr  out  ADDR_W  destination byte address
- tlp_qwords  out  5  payload qwords
- tlp_is_hdr  out  1  request is a header write; payload = final offset
- tlp_hdr_data  out  OFFSET_W  qword count written in the header
- cur_slot  out  1  active slot

Behaviour:
- Reset values: all outputs 0; offset = HDR_QWORDS; cur_slot = 0; hp_ready = 2'b00; FSM = IDLE. Reset mid-operation abandons any outstanding request with no ack.
- Slot write: hp_wr_en latches the base address and sets hp_ready[sel].
  - A write to a slot already ready overwrites the address; the flag stays 1.
  - A write to cur_slot while a request to it is outstanding is held off: the write is applied in the cycle after the FSM returns to IDLE.
- Address arithmetic: tlp_host_addr = base[cur_slot] + {offset, 3'b000}, registered. Offset adds are unsigned and width OFFSET_W, with no wrap check here; the 2 MB limit is the trigger's responsibility.
- FSM states: IDLE, DATA, HDR, SWAP, ACK.
  - IDLE, request precedence: change_huge_page > send_last_tlp > trigger_tlp. A request is taken only when hp_ready[cur_slot] = 1; otherwise the ctrl stalls with no ack.
    - trigger_tlp -> DATA (last = 0).
    - send_last_tlp -> DATA (last = 1).
    - change_huge_page -> HDR.
  - DATA: tlp_req = 1, tlp_qwords = qwords_to_send (latched on entry), tlp_is_hdr = 0. On tlp_gnt, offset += qwords.
    - last = 0: pulse trigger_tlp_ack and go to IDLE.
    - last = 1: go to HDR.
  - HDR: tlp_req = 1, tlp_is_hdr = 1, tlp_qwords = 1, address = base[cur_slot] (offset 0), tlp_hdr_data = offset. On tlp_gnt -> SWAP.
  - SWAP: clear hp_ready[cur_slot], toggle cur_slot, offset = HDR_QWORDS -> ACK.
  - ACK: pulse change_huge_page_ack for 1 cycle -> IDLE.
- tlp_req stays high from the first request cycle until tlp_gnt. The address, qwords and header fields are stable throughout and change only after the gnt.
- Latency:
  - Data request: tlp_req rises 1 cycle after accept; ack is issued in the cycle after gnt.
  - Close: ack is issued 2 cycles after the header gnt.
- Simultaneous hp_wr_en targeting the slot being cleared in SWAP: the write wins and the slot stays ready.
- An empty page (offset = HDR_QWORDS) is still closed, with a header value of 16.

Optional Feature:
- RX_HP_STALL_CNT_EN
  - Defined: adds output stall_cycles[31:0], which counts cycles in IDLE where a request is pending but hp_ready[cur_slot] = 0. The counter saturates at 0xFFFFFFFF and resets to 0.
  - Undefined: no port and no counter; behaviour is otherwise identical.

Decomposition:
- Shared package/includes: FSM state encodings, HDR_QWORDS, OFFSET_W, the 2 MB page-size constant.
- One natural sub-module, rx_hp_slot_regs: the two base registers, ready flags, deferred-write logic and address mux. The FSM stays in the top.

Test Plan:
- No slot written, trigger_tlp with qwords = 16: no tlp_req and no ack for 100 cycles. Then write slot 0 = 0x1_0000_0000: tlp_req rises with addr 0x1_0000_0080, qwords 16.
- Three triggers of 16, gnt after 0, 3 and 7 cycles: addrs base+0x80, +0x100, +0x180. Fields stay stable while req is held; exactly one ack per trigger.
- send_last_tlp, qwords = 5, after one 16-qword TLP: data TLP at base+0x100 (5 qw), then header at base with data 37. Then hp_ready = 2'b10, cur_slot = 1, one change_huge_page_ack.
- change_huge_page and trigger_tlp asserted together: header TLP first. After swap, the data TLP targets slot1 base+0x80.
- hp_wr_en to cur_slot while a DATA request is pending: the address is unchanged until IDLE, and the new base is used by the next request.
- reset_n low while tlp_req = 1: all outputs go to 0 immediately and hp_ready = 0. After release, no ack is ever emitted for the old request.
